// File: rtl/pixel_scheduler.sv
// pixel_scheduler: walks every pixel of a frame, runs the point generator on it
// and writes the saturated iteration count to the frame buffer in raster order.
module pixel_scheduler #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int HBI    = 32,
    parameter int ADDR_W = 19
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              go,
    output logic              pg_start,
    output logic [11:0]       pg_x,
    output logic [11:0]       pg_y,
    input  logic              pg_done,
    input  logic [HBI-1:0]    pg_iteration,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              frame_done
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, ADV} state_t;
    state_t state, state_n;
    logic last_col, last_pix;
    assign last_col = pg_x == 12'(H_RES - 1);
    assign last_pix = last_col && pg_y == 12'(V_RES - 1);
    always_comb begin
        state_n    = state;
        pg_start   = 1'b0;
        wr_en      = 1'b0;
        frame_done = 1'b0;
        busy       = state != IDLE;
        case (state)
            IDLE:    state_n = go ? ISSUE : IDLE;
            ISSUE: begin
                pg_start = 1'b1;
                state_n  = WAIT;
            end
            WAIT:    state_n = pg_done ? WRITE : WAIT;
            WRITE: begin
                wr_en   = 1'b1;
                state_n = wr_ready ? ADV : WRITE;
            end
            ADV: begin
                frame_done = last_pix;
                state_n    = last_pix ? IDLE : ISSUE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            pg_x    <= '0;
            pg_y    <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && go) begin
                pg_x    <= '0;
                pg_y    <= '0;
                wr_addr <= '0;
            end
            if (state == WAIT && pg_done)
                wr_data <= (pg_iteration > HBI'(255)) ? 8'd255 : 8'(pg_iteration);
            // raster address tracks y*H_RES+x by counting instead of multiplying
            if (state == ADV && !last_pix) begin
                pg_x    <= last_col ? 12'd0 : pg_x + 12'd1;
                pg_y    <= last_col ? pg_y + 12'd1 : pg_y;
                wr_addr <= wr_addr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler: 4x3 frame with a 5-cycle generator model; raster-order
// scoreboard of expected writes plus literal pins on captured pixel values.
module tb_pixel_scheduler;
    localparam int HR = 4, VR = 3, NPIX = HR * VR;
    logic       CLK = 0, RST = 1, go = 0, pg_start, pg_done = 0, wr_en, wr_ready = 1, busy, frame_done;
    logic [11:0] pg_x, pg_y;
    logic [31:0] pg_iteration = 0;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    int checks = 0, errors = 0;
    int mode = 0, stall_en = 0, stall_n = 0, stall_cnt = 0;
    int widx = 0, starts = 0, fdone = 0, gcnt = 0, lx = 0, ly = 0;
    int cap [NPIX];
    logic prev_stall = 0;
    logic [3:0] prev_a;
    logic [7:0] prev_d;

    pixel_scheduler #(.H_RES(HR), .V_RES(VR), .HBI(32), .ADDR_W(4)) dut (
        .CLK(CLK), .RST(RST), .go(go), .pg_start(pg_start), .pg_x(pg_x), .pg_y(pg_y),
        .pg_done(pg_done), .pg_iteration(pg_iteration), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .frame_done(frame_done));

    always #5 CLK = ~CLK;

    function automatic int iter_of(int x, int y);
        if (mode == 1 && y == 0 && x == 0) return 300;
        if (mode == 1 && y == 0 && x == 1) return 255;
        if (mode == 1 && y == 0 && x == 2) return 7;
        return x + y;
    endfunction

    function automatic int sat(int v);
        return v > 255 ? 255 : v;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // generator and frame-buffer stand-ins, acting just after each rising edge
    initial forever begin
        @(posedge CLK);
        #1;
        if (RST) begin
            gcnt = 0;
        end else if (pg_start) begin
            pg_done = 0;
            gcnt = 5;
            lx = int'(pg_x);
            ly = int'(pg_y);
        end else if (gcnt > 0) begin
            gcnt--;
            if (gcnt == 0) begin
                pg_done = 1;
                pg_iteration = 32'(iter_of(lx, ly));
            end
        end
        if (stall_en != 0 && wr_en && wr_addr == 4'd5 && stall_n < 4) begin
            wr_ready = 0;
            stall_n++;
        end else wr_ready = 1;
    end

    // scoreboard: writes must appear in raster order with saturated values
    always @(negedge CLK) begin
        if (RST) prev_stall = 0;
        else begin
            if (pg_start) starts++;
            if (prev_stall) begin
                chk(wr_en, "stall_wr_en", int'(wr_en), 1);
                chk(wr_addr == prev_a, "stall_addr", int'(wr_addr), int'(prev_a));
                chk(wr_data == prev_d, "stall_data", int'(wr_data), int'(prev_d));
                chk(!pg_start, "stall_no_restart", int'(pg_start), 0);
            end
            prev_stall = wr_en && !wr_ready;
            prev_a = wr_addr;
            prev_d = wr_data;
            if (prev_stall) stall_cnt++;
            if (wr_en) begin
                chk(widx < NPIX, "extra_write", widx, NPIX - 1);
                if (widx < NPIX) begin
                    chk(int'(wr_addr) == widx, "wr_addr", int'(wr_addr), widx);
                    chk(int'(wr_data) == sat(iter_of(widx % HR, widx / HR)), "wr_data",
                        int'(wr_data), sat(iter_of(widx % HR, widx / HR)));
                    chk(int'(pg_x) == widx % HR && int'(pg_y) == widx / HR, "pg_xy",
                        int'(pg_x) * 100 + int'(pg_y), (widx % HR) * 100 + widx / HR);
                    chk(busy, "busy_in_write", int'(busy), 1);
                    if (wr_ready) begin
                        cap[widx] = int'(wr_data);
                        widx++;
                    end
                end
            end
            if (frame_done) begin
                fdone++;
                chk(widx == NPIX, "done_after_last", widx, NPIX);
            end
        end
    end

    task automatic pulse_go();
        @(posedge CLK);
        #1 go = 1;
        @(posedge CLK);
        #1 go = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!frame_done && n < 1000);
        chk(n < 1000, "frame_timeout", n, 1000);
        repeat (2) @(negedge CLK);
        chk(!busy, "busy_after", int'(busy), 0);
        chk(fdone == 1, "frame_done_count", fdone, 1);
        chk(widx == NPIX, "write_count", widx, NPIX);
        chk(starts == NPIX, "start_count", starts, NPIX);
    endtask

    task automatic run_frame(input int m, input int st);
        mode = m; stall_en = st; stall_n = 0; stall_cnt = 0;
        widx = 0; starts = 0; fdone = 0;
        pulse_go();
        repeat (10) @(posedge CLK);
        pulse_go();
        repeat (30) @(posedge CLK);
        pulse_go();
        wait_done();
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk(!busy && !pg_start && !wr_en && !frame_done, "reset_ctrl",
            int'({busy, pg_start, wr_en, frame_done}), 0);
        chk(pg_x == 0 && pg_y == 0 && wr_addr == 0 && wr_data == 0, "reset_data",
            int'(pg_x) + int'(pg_y) + int'(wr_addr) + int'(wr_data), 0);
        @(posedge CLK);
        #1 RST = 0;

        run_frame(0, 0);
        chk(cap[0] == 0 && cap[3] == 3, "lit_row0", cap[0] * 100 + cap[3], 3);
        chk(cap[5] == 2 && cap[11] == 5, "lit_row12", cap[5] * 100 + cap[11], 205);
        pg_done = 1;
        repeat (20) @(negedge CLK);
        chk(starts == NPIX && widx == NPIX && !busy, "idle_ignores_done",
            starts * 100 + widx, NPIX * 100 + NPIX);

        run_frame(1, 0);
        chk(cap[0] == 255, "sat_300", cap[0], 255);
        chk(cap[1] == 255, "sat_255", cap[1], 255);
        chk(cap[2] == 7, "sat_7", cap[2], 7);

        run_frame(0, 1);
        chk(stall_cnt == 4, "stall_cycles", stall_cnt, 4);
        chk(cap[5] == 2, "lit_stalled_pix", cap[5], 2);

        mode = 0; stall_en = 0; widx = 0; starts = 0; fdone = 0;
        pulse_go();
        begin
            int n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!(pg_start && pg_x == 2 && pg_y == 1) && n < 1000);
            chk(n < 1000, "pix6_timeout", n, 1000);
        end
        @(posedge CLK);
        #1 RST = 1;
        #1;
        chk(!busy && !pg_start && !wr_en && !frame_done, "rst_mid_ctrl",
            int'({busy, pg_start, wr_en, frame_done}), 0);
        chk(pg_x == 0 && pg_y == 0 && wr_addr == 0 && wr_data == 0, "rst_mid_data",
            int'(pg_x) + int'(pg_y) + int'(wr_addr) + int'(wr_data), 0);
        chk(widx == 6 && fdone == 0, "abandoned", widx * 10 + fdone, 60);
        repeat (3) @(posedge CLK);
        #1 RST = 0;

        run_frame(0, 0);
        chk(cap[0] == 0 && cap[7] == 4, "lit_restart", cap[0] * 100 + cap[7], 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_scheduler.md
PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 SHALL have parameter H_RES, default 640, horizontal pixel count (x range 0..H_RES-1).
REQ-002 SHALL have parameter V_RES, default 480, vertical pixel count (y range 0..V_RES-1).
REQ-003 SHALL have parameter HBI, default 32, iteration count width from the point generator.
REQ-004 SHALL have parameter ADDR_W, default 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port CLK  input  1  rising-edge clock.
REQ-007 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-008 SHALL have port go  input  1  frame request, sampled only in IDLE.
REQ-009 SHALL have port pg_start  output  1  one-cycle start pulse to the point generator.
REQ-010 SHALL have port pg_x  output  12  current pixel column.
REQ-011 SHALL have port pg_y  output  12  current pixel row.
REQ-012 SHALL have port pg_done  input  1  point generator finished; level, cleared by generator on start.
REQ-013 SHALL have port pg_iteration  input  HBI  escape iteration count.
REQ-014 SHALL have port wr_en  output  1  frame-buffer write request.
REQ-015 SHALL have port wr_addr  output  ADDR_W  write address.
REQ-016 SHALL have port wr_data  output  8  pixel value.
REQ-017 SHALL have port wr_ready  input  1  frame buffer accepts write when high with wr_en.
REQ-018 SHALL have port busy  output  1  high from frame start until frame_done.
REQ-019 SHALL have port frame_done  output  1  one-cycle pulse after last pixel write accepted.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, WRITE, ADV.
REQ-021 IDLE: on go=1, SHALL clear x, y, addr to 0, set busy=1, go to ISSUE; go while busy SHALL be ignored.
REQ-022 ISSUE: SHALL assert pg_start for exactly one cycle, then go to WAIT.
REQ-023 WAIT: SHALL sample pg_done from the first cycle after ISSUE; on pg_done=1 SHALL latch pg_iteration and go to WRITE.
REQ-024 pg_x, pg_y SHALL remain stable from ISSUE through WRITE.
REQ-025 Latched value SHALL be saturated: wr_data = 255 if iteration > 255, else iteration[7:0].
REQ-026 WRITE: wr_en=1 with wr_addr, wr_data held stable until wr_ready=1; transfer completes on the edge where both are high.
REQ-027 wr_addr SHALL equal y*H_RES + x, maintained by an incrementing counter (no multiplier).
REQ-028 ADV: x increments; at x=H_RES-1, x wraps to 0 and y increments; addr increments; next state ISSUE.
REQ-029 At pixel (H_RES-1, V_RES-1), ADV SHALL instead pulse frame_done for one cycle, clear busy, go to IDLE.
REQ-030 pg_done high in IDLE, ISSUE or ADV SHALL be ignored.
REQ-031 Per-pixel overhead SHALL be 3 cycles plus generator time plus wr_ready stall cycles.

Reset
REQ-032 RST=1 SHALL asynchronously force IDLE, x=y=addr=0, pg_start=0, wr_en=0, wr_data=0, busy=0, frame_done=0, latched iteration=0.
REQ-033 Reset mid-frame SHALL abandon the frame with no write and no frame_done; next go restarts at (0,0).

Verification (H_RES=4, V_RES=3, model generator returns iteration = x+y after 5 cycles)
REQ-034 go pulse, wr_ready=1 -> 12 writes, addr 0..11 in order, wr_data=x+y, frame_done one pulse, busy low after.
REQ-035 model returns iteration 300 -> wr_data=255; iteration 255 -> 255; 7 -> 7.
REQ-036 wr_ready held low 4 cycles at pixel 5 -> wr_en, wr_addr=5, wr_data stable; single write accepted; pg_start not reissued meanwhile.
REQ-037 RST asserted during WAIT of pixel 6 -> outputs at reset values immediately; new go -> first write addr 0.
REQ-038 go pulsed during busy and pg_done stuck high in IDLE -> no extra frame, no write, pg_start count equals 12.
